// File: rtl/mulacc_pkg.sv
// Shared types and defaults for the multiply-accumulate accumulate stage.
package mulacc_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int PROD_W_DEFAULT = 8;
    localparam int ACC_W_DEFAULT  = 12;
    localparam int LEN_W_DEFAULT  = 4;

endpackage

// File: rtl/mulacc_ext_add.sv
// Extends a product to accumulator width, adds it, and flags overflow in the selected signedness.
// With MULACC_SAT_EN defined the result clamps to the mode's limit on overflow; otherwise it wraps.
module mulacc_ext_add
    import mulacc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEFAULT,
    parameter int ACC_W  = ACC_W_DEFAULT
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    input  logic              is_signed,
    output logic [ACC_W-1:0]  result,
    output logic              ovf
);

    logic [ACC_W-1:0] ext;
    logic [ACC_W:0]   raw;

    always_comb begin
        ext = '0;
        ext[PROD_W-1:0] = prod;
        for (int i = PROD_W; i < ACC_W; i++) begin
            ext[i] = is_signed & prod[PROD_W-1];
        end
    end

    assign raw = {1'b0, acc} + {1'b0, ext};

    // Signed overflow: like-signed operands producing a result of the other sign.
    always_comb begin
        if (is_signed) begin
            ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
        end else begin
            ovf = raw[ACC_W];
        end
    end

`ifdef MULACC_SAT_EN
    localparam logic [ACC_W-1:0] UMAX = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

    always_comb begin
        result = raw[ACC_W-1:0];
        if (ovf) begin
            if (!is_signed) begin
                result = UMAX;
            end else if (acc[ACC_W-1]) begin
                result = SMIN;
            end else begin
                result = SMAX;
            end
        end
    end
`else
    assign result = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/mul_accumulator.sv
// Sums a burst of unsigned or signed products into a wide accumulator and presents the total.
// Optional saturation is selected with MULACC_SAT_EN (see mulacc_ext_add).
module mul_accumulator
    import mulacc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEFAULT,
    parameter int ACC_W  = ACC_W_DEFAULT,
    parameter int LEN_W  = LEN_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              is_signed,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
    // a producer holding valid keeps its data stable until that edge, ready may change freely.

    state_t            state, state_nxt;
    logic [ACC_W-1:0]  acc;
    logic [LEN_W-1:0]  cnt;
    logic              mode_signed;
    logic              ovf_r;
    logic [ACC_W-1:0]  add_res;
    logic              add_ovf;
    logic              in_xfer;

    mulacc_ext_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_ext_add (
        .acc       (acc),
        .prod      (prod),
        .is_signed (mode_signed),
        .result    (add_res),
        .ovf       (add_ovf)
    );

    assign in_xfer = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid && cnt == LEN_W'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            cnt         <= '0;
            mode_signed <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (state == S_IDLE && start) begin
            acc         <= '0;
            cnt         <= len;
            mode_signed <= is_signed;
            ovf_r       <= 1'b0;
        end else if (in_xfer) begin
            acc   <= add_res;
            cnt   <= cnt - LEN_W'(1);
            ovf_r <= ovf_r | add_ovf;
        end
    end

    assign sum       = acc;
    assign ovf       = ovf_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed bench for mul_accumulator: a 12-bit and an 8-bit accumulator share one stimulus stream.
module tb_mul_accumulator;
    import mulacc_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] len = '0;
    logic       is_signed = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] prod = '0;
    logic       out_ready = 1'b0;

    logic        busy12, in_ready12, out_valid12, ovf12;
    logic [11:0] sum12;
    logic [1:0]  st12;
    logic        busy8, in_ready8, out_valid8, ovf8;
    logic [7:0]  sum8;
    logic [1:0]  st8;

    int checks = 0;
    int errors = 0;

    mul_accumulator #(.PROD_W(8), .ACC_W(12), .LEN_W(4)) dut12 (
        .clk(clk), .reset(reset), .start(start), .len(len), .is_signed(is_signed),
        .busy(busy12), .in_valid(in_valid), .in_ready(in_ready12), .prod(prod),
        .out_valid(out_valid12), .out_ready(out_ready), .sum(sum12), .ovf(ovf12),
        .dbg_state(st12)
    );

    mul_accumulator #(.PROD_W(8), .ACC_W(8), .LEN_W(4)) dut8 (
        .clk(clk), .reset(reset), .start(start), .len(len), .is_signed(is_signed),
        .busy(busy8), .in_valid(in_valid), .in_ready(in_ready8), .prod(prod),
        .out_valid(out_valid8), .out_ready(out_ready), .sum(sum8), .ovf(ovf8),
        .dbg_state(st8)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks: every step leaves us 1 time unit after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_burst(input logic [3:0] n, input logic sgn);
        start = 1'b1;
        len = n;
        is_signed = sgn;
        step();
        start = 1'b0;
        len = 4'hF;
        is_signed = ~sgn;
    endtask

    task automatic xfer(input logic [7:0] p);
        in_valid = 1'b1;
        prod = p;
        step();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        // reset state
        step();
        check("rst_busy", busy12, 0);
        check("rst_state", st12, S_IDLE);
        check("rst_sum", sum12, 0);
        check("rst_outs", {in_ready12, out_valid12, ovf12}, 0);
        reset = 1'b0;
        step();

        // 1: unsigned 225 x3 back-to-back
        begin_burst(4'd3, 1'b0);
        check("t1_in_ready", in_ready12, 1);
        xfer(8'd225);
        xfer(8'd225);
        check("t1_not_done", out_valid12, 0);
        check("t1_partial", sum12, 12'd450);
        xfer(8'd225);
        in_valid = 1'b0;
        check("t1_out_valid", out_valid12, 1);
        check("t1_sum", sum12, 12'h2A3);
        check("t1_ovf", ovf12, 0);
        check("t1_in_ready_done", in_ready12, 0);
        drain();
        check("t1_idle", {busy12, out_valid12}, 0);

        // 2: signed -56 then 64 with a 2-cycle gap
        begin_burst(4'd2, 1'b1);
        xfer(8'hC8);
        in_valid = 1'b0;
        prod = 8'h7F;
        step();
        step();
        check("t2_gap_sum", sum12, 12'hFC8);
        check("t2_gap_state", st12, S_ACCUM);
        xfer(8'h40);
        in_valid = 1'b0;
        check("t2_out_valid", out_valid12, 1);
        check("t2_sum", sum12, 12'h008);
        check("t2_ovf", ovf12, 0);
        drain();

        // 3: zero-length burst
        start = 1'b1;
        len = 4'd0;
        is_signed = 1'b0;
        #1;
        check("t3_in_ready_idle", in_ready12, 0);
        step();
        start = 1'b0;
        check("t3_out_valid", out_valid12, 1);
        check("t3_in_ready", in_ready12, 0);
        check("t3_sum", sum12, 0);
        drain();
        check("t3_back_idle", {busy12, out_valid12}, 0);

        // 4: back-pressure on the output, start ignored while DONE
        begin_burst(4'd1, 1'b0);
        xfer(8'd5);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len = 4'd3;
            step();
            check("t4_hold", {out_valid12, in_ready12, ovf12, sum12}, {3'b100, 12'd5});
        end
        // start held across the output handshake must not launch a burst
        start = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b0;
        check("t4_no_relaunch", st12, S_IDLE);
        step();
        check("t4_still_idle", busy12, 0);

        // 5: 8-bit accumulator overflow, unsigned then signed
        begin_burst(4'd2, 1'b0);
        xfer(8'd200);
        xfer(8'd100);
        in_valid = 1'b0;
        check("t5u_ovf8", ovf8, 1);
`ifdef MULACC_SAT_EN
        check("t5u_sum8", sum8, 8'd255);
`else
        check("t5u_sum8", sum8, 8'd44);
`endif
        check("t5u_sum12", sum12, 12'd300);
        check("t5u_ovf12", ovf12, 0);
        drain();
        begin_burst(4'd2, 1'b1);
        check("t5s_ovf_cleared", ovf8, 0);
        xfer(8'd64);
        xfer(8'd64);
        in_valid = 1'b0;
        check("t5s_ovf8", ovf8, 1);
`ifdef MULACC_SAT_EN
        check("t5s_sum8", sum8, 8'h7F);
`else
        check("t5s_sum8", sum8, 8'h80);
`endif
        check("t5s_sum12", sum12, 12'h080);
        check("t5s_ovf12", ovf12, 0);
        drain();

        // 6: asynchronous reset mid-burst, then a fresh burst
        begin_burst(4'd4, 1'b0);
        xfer(8'd7);
        xfer(8'd8);
        in_valid = 1'b0;
        check("t6_mid_sum", sum12, 12'd15);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_outs", {busy12, in_ready12, out_valid12, ovf12}, 0);
        check("t6_async_sum", sum12, 0);
        check("t6_async_state", st12, S_IDLE);
        step();
        reset = 1'b0;
        step();
        begin_burst(4'd1, 1'b0);
        xfer(8'd9);
        in_valid = 1'b0;
        check("t6_new_valid", out_valid12, 1);
        check("t6_new_sum", sum12, 12'd9);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_accumulator.md
Name: mul_accumulator

Overview:
- Downstream consumer of the 4x4 multiplier stage.
- Accepts a burst of 8-bit products (unsigned or signed per burst) over a valid/ready handshake and sums them into a wider accumulator.
- Presents the total on an output handshake.
- Forms the accumulate half of the team's multiply-accumulate datapath.

Parameters:
- PROD_W, 8: product width, matches the multiplier output.
- ACC_W, 12: accumulator/sum width. Minimum 8. Default holds 15 worst-case products in either signedness.
- LEN_W, 4: width of the burst-length field. Max burst is 2^LEN_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a burst. Sampled only in IDLE.
- len  input  LEN_W  number of products in the burst. Sampled with start.
- is_signed  input  1  1 = products are two's complement. Sampled with start.
- busy  output  1  high in ACCUM and DONE.
- in_valid  input  1  prod is valid.
- in_ready  output  1  block accepts prod.
- prod  input  PROD_W  product from the multiplier.
- out_valid  output  1  sum is valid.
- out_ready  input  1  consumer accepts sum.
- sum  output  ACC_W  accumulated result.
- ovf  output  1  sticky overflow for the current burst.

Behaviour:
- Reset, asynchronous, any state including mid-burst:
  - state=IDLE.
  - acc, cnt, latched mode = 0.
  - busy, in_ready, out_valid, ovf = 0; sum = 0.
  - Any in-flight burst is discarded.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1: latch is_signed, load cnt=len, clear acc and ovf.
  - len!=0 -> ACCUM; len==0 -> DONE with sum=0.
- ACCUM:
  - in_ready=1.
  - A transfer occurs on in_valid && in_ready:
    - acc <= acc + ext(prod), where ext = sign-extension if latched signed, zero-extension otherwise, to ACC_W.
    - cnt <= cnt-1.
  - The transfer with cnt==1 moves to DONE.
  - Idle cycles (in_valid=0) hold all state.
- DONE:
  - in_ready=0, out_valid=1; sum=acc and ovf are held stable.
  - On out_ready=1 -> IDLE. out_valid drops the next cycle.
  - The block may leave IDLE no earlier than one cycle after the out handshake.
- start is ignored in ACCUM and DONE. len and is_signed changes outside the start cycle have no effect.
- Latency: out_valid rises the cycle after the final input transfer; for len==0, the cycle after start.
- Throughput: one product per cycle in ACCUM.
- Overflow:
  - Computed on each add in the latched signedness.
  - Unsigned: carry out of ACC_W. Signed: operands of like sign give a result of opposite sign.
  - Sets ovf, which stays set until the next start or reset.
  - Default (no saturation): acc wraps modulo 2^ACC_W.
- sum is combinationally equal to acc in every state.

Optional Feature:
- Macro: MULACC_SAT_EN.
- Defined: on overflow, acc clamps to the limit of the latched mode (unsigned 2^ACC_W-1; signed 2^(ACC_W-1)-1 or -2^(ACC_W-1)). Later adds continue from the clamped value. ovf is still set.
- Undefined: wrap-around as above. No saturation logic is synthesised.

Decomposition:
- Package mulacc_pkg:
  - typedef enum logic [1:0] state_t {S_IDLE, S_ACCUM, S_DONE}.
  - Localparam PROD_W_DEFAULT=8.
- Sub-module mulacc_ext_add (combinational): extend prod, add to acc, flag overflow, and under MULACC_SAT_EN clamp the result. Instantiated once in mul_accumulator.

Test Plan:
1. Unsigned, len=3, prods 225,225,225 back-to-back -> out_valid the cycle after the 3rd transfer, sum=675 (12'h2A3), ovf=0.
2. Signed, len=2, prods 8'hC8 (-56), 8'h40 (64), with a 2-cycle in_valid gap -> sum=12'h008, ovf=0. Gap cycles hold state.
3. len=0, start pulse -> in_ready never rises; out_valid=1 next cycle, sum=0; back to IDLE on out_ready.
4. Burst done, out_ready low for 5 cycles, start pulsed -> sum, out_valid, ovf stable; in_ready=0; start ignored.
5. ACC_W=8, unsigned, len=2, prods 200,100 -> ovf=1; sum=44 without MULACC_SAT_EN, sum=255 with it. Signed, prods 64,64 -> ovf=1; sum=-128 wrap, or 127 saturated.
6. reset asserted mid-ACCUM after 2 of 4 transfers -> all outputs 0 immediately (async); a new start with len=1, prod 9 -> sum=9.
